// File: rtl/window_generator.sv
// window_generator
//   Streaming KxK sliding-window producer for the convolution datapath.
//   Accepts one raster-order pixel per handshake, keeps the previous K-1 rows
//   in line buffers plus a KxK window register, and presents one flattened
//   window for every valid output position ("valid" convolution, stride 1).
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset; release starts a new frame
//   pixel_in     next raster-order pixel (bit-exact pass-through)
//   in_valid     pixel_in is valid
//   in_ready     pixel accepted when in_valid && in_ready
//   pixel_data   flattened window, slot s = i*K + j at [s*DATA_WIDTH +: DATA_WIDTH],
//                slot 0 = top-left (oldest), slot K*K-1 = completing pixel
//   out_valid    pixel_data holds an unconsumed window
//   out_ready    window consumed when out_valid && out_ready
//   last_window  qualifies out_valid: final window of the frame
module window_generator #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [DATA_WIDTH-1:0]                      pixel_in,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       last_window
);

  localparam int K   = KERNEL_SIZE;
  localparam int NLB = KERNEL_SIZE - 1;
  localparam int CW  = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_lb  [NLB][IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] r_win [K][K];
  logic                  r_out_valid;
  logic                  r_last;

  logic [DATA_WIDTH-1:0] w_newcol [K];
  logic                  w_accept;
  logic                  w_win_done;
  logic                  w_frame_end;

  // A new window may only load once the held one is gone (or leaves now),
  // which is what keeps pixel_data stable under backpressure.
  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_win_done  = (r_row >= ROW_FIRST) && (r_col >= COL_FIRST);
  assign w_frame_end = (r_row == ROW_LAST) && (r_col == COL_LAST);

  assign out_valid   = r_out_valid;
  assign last_window = r_last;

  // New right-hand window column: line buffers oldest (top) to newest, then
  // the incoming pixel at the bottom. Line buffer 0 holds the previous row.
  for (genvar gi = 0; gi < NLB; gi++) begin : g_col
    assign w_newcol[gi] = r_lb[NLB-1-gi][r_col];
  end
  assign w_newcol[K-1] = pixel_in;

  // Line buffers carry no reset: stale rows are masked by counter gating.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][r_col] <= pixel_in;
      for (int unsigned k = 1; k < NLB; k++) begin
        r_lb[k][r_col] <= r_lb[k-1][r_col];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      for (int unsigned i = 0; i < K; i++) begin
        for (int unsigned j = 0; j < K; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int unsigned i = 0; i < K; i++) begin
        for (int unsigned j = 0; j + 1 < K; j++) begin
          r_win[i][j] <= r_win[i][j+1];
        end
        r_win[i][K-1] <= w_newcol[i];
      end
      r_out_valid <= w_win_done;
      r_last      <= w_win_done && w_frame_end;
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_slot
      assign pixel_data[(gi*K+gj)*DATA_WIDTH +: DATA_WIDTH] = r_win[gi][gj];
    end
  end

endmodule

// File: tb/tb_window_generator.sv
module tb_window_generator;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = K*K*DW;
  localparam int NWIN = (W-K+1)*(H-K+1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] pixel_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          last_window;

  window_generator #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_in   (pixel_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixel_data (pixel_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .last_window(last_window)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: an image array, a raster position and a queue of the
  // windows expected in consumption order.
  logic [DW-1:0] img [H][W];
  int            mr, mc;
  bit            mvalid;
  logic [PW-1:0] expq [$];
  bit            expl [$];
  logic [PW-1:0] got  [$];
  logic [PW-1:0] full [$];
  int            nlast;
  bit            hold_v;
  logic [PW-1:0] hold_d;
  bit            hold_l;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0; mvalid = 0; hold_v = 0;
    expq.delete(); expl.delete();
  endtask

  task automatic model_accept(input logic [DW-1:0] px);
    logic [PW-1:0] w;
    img[mr][mc] = px;
    if (mr >= K-1 && mc >= K-1) begin
      w = '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          w[(i*K+j)*DW +: DW] = img[mr-K+1+i][mc-K+1+j];
      expq.push_back(w);
      expl.push_back(mr == H-1 && mc == W-1);
      mvalid = 1;
    end else begin
      mvalid = 0;
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic step(input bit iv, input logic [DW-1:0] px, input bit ordy, output bit acc);
    logic [PW-1:0] e;
    bit l;
    in_valid = iv; pixel_in = px; out_ready = ordy;
    @(negedge clk);
    chk("in_ready", PW'(in_ready), PW'(!mvalid || ordy));
    chk("out_valid", PW'(out_valid), PW'(mvalid));
    if (hold_v) begin
      chk("hold_data", pixel_data, hold_d);
      chk("hold_last", PW'(last_window), PW'(hold_l));
    end
    hold_v = out_valid && !ordy;
    hold_d = pixel_data;
    hold_l = last_window;
    if (out_valid && ordy) begin
      if (expq.size() == 0) begin
        chk("unexpected_window", PW'(1), PW'(0));
      end else begin
        e = expq.pop_front();
        l = expl.pop_front();
        chk("window", pixel_data, e);
        chk("last", PW'(last_window), PW'(l));
      end
      got.push_back(pixel_data);
      if (last_window) nlast++;
    end
    acc = iv && (!mvalid || ordy);
    if (acc) model_accept(px);
    else if (mvalid && ordy) mvalid = 0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    bit acc;
    repeat (n) step(1'b0, '0, 1'b1, acc);
  endtask

  // mode 0: full rate; 1: random input bubbles; 2: one 10-clk stall plus random out_ready
  task automatic send_frame(input int npix, input int mode, input logic [DW-1:0] tag);
    int sent = 0;
    int cyc = 0;
    bit stalled = 0;
    bit acc, iv, ordy;
    logic [DW-1:0] px;
    while (sent < npix && cyc < 5000) begin
      px = DW'(mr*W + mc) | tag;
      if (mode == 2 && !stalled && mvalid && got.size() >= 3) begin
        stalled = 1;
        repeat (10) step(1'b1, px, 1'b0, acc);
      end
      iv   = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
      ordy = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(iv, px, ordy, acc);
      if (acc) sent++;
      cyc++;
    end
    if (cyc >= 5000) chk("send_timeout", PW'(sent), PW'(npix));
  endtask

  task automatic slots(input string tag, input logic [PW-1:0] w, input int s0, input int s8);
    chk({tag, "_slot0"}, PW'(w[0 +: DW]), PW'(s0));
    chk({tag, "_slot8"}, PW'(w[8*DW +: DW]), PW'(s8));
  endtask

  task automatic same_as_full(input string tag);
    chk({tag, "_count"}, PW'(got.size()), PW'(full.size()));
    for (int i = 0; i < got.size() && i < full.size(); i++)
      chk(tag, got[i], full[i]);
  endtask

  initial begin
    logic [PW-1:0] t;

    // Reset held with in_valid asserted.
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_last", PW'(last_window), PW'(0));
    chk("rst_data", pixel_data, '0);
    chk("rst_in_ready", PW'(in_ready), PW'(1));
    model_reset();
    reset = 1'b1;

    // Full-rate frame.
    got.delete(); nlast = 0;
    send_frame(W*H, 0, '0);
    drain(3);
    chk("full_count", PW'(got.size()), PW'(NWIN));
    chk("full_nlast", PW'(nlast), PW'(1));
    if (got.size() == NWIN) begin
      t = got[0];
      slots("first", t, 0, 2*W+2);
      chk("first_slot4", PW'(t[4*DW +: DW]), PW'(W+1));
      t = got[NWIN-1];
      slots("lastwin", t, (H-K)*W + (W-K), (H-1)*W + (W-1));
    end
    full = got;

    // Input bubbles must give the identical window sequence.
    got.delete(); nlast = 0;
    send_frame(W*H, 1, '0);
    drain(3);
    same_as_full("bubbles");
    chk("bubbles_nlast", PW'(nlast), PW'(1));

    // Backpressure: a 10-clk stall and random out_ready.
    got.delete(); nlast = 0;
    send_frame(W*H, 2, '0);
    drain(3);
    same_as_full("backpressure");
    chk("bp_nlast", PW'(nlast), PW'(1));

    // Two frames back to back.
    got.delete(); nlast = 0;
    send_frame(2*W*H, 0, '0);
    drain(3);
    chk("b2b_count", PW'(got.size()), PW'(2*NWIN));
    chk("b2b_nlast", PW'(nlast), PW'(2));
    if (got.size() > NWIN) begin
      t = got[NWIN];
      slots("frame2_first", t, 0, 2*W+2);
    end

    // Async reset right after accepting (3,4), with tagged pixels.
    got.delete(); nlast = 0;
    send_frame(3*W + 5, 0, 16'h4000);
    chk("pre_rst_valid", PW'(out_valid), PW'(1));
    reset = 1'b0;
    #1;
    chk("arst_out_valid", PW'(out_valid), PW'(0));
    chk("arst_last", PW'(last_window), PW'(0));
    chk("arst_data", pixel_data, '0);
    chk("arst_in_ready", PW'(in_ready), PW'(1));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    got.delete(); nlast = 0;
    send_frame(W*H, 1, '0);
    drain(3);
    same_as_full("after_reset");
    chk("after_reset_nlast", PW'(nlast), PW'(1));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
